// File: rtl/fetch_stage.sv
// fetch_stage: Otter IF stage with 1-cycle synchronous imem, skid-buffered stall-safe output and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        IF_CLK,
  input  logic        IF_RST_N,
  input  logic [1:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic        STALL,
  input  logic [31:0] MEM_INSTR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RDEN,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_IR,
  output logic        IF_VALID,
  output logic        FLUSH
);
  logic [31:0] pc, req_pc, skid_pc, skid_ir, target;
  logic        req_valid, skid_valid, redirect;
  assign redirect = PC_SOURCE != 2'b00;
  assign FLUSH    = redirect;
  assign MEM_ADDR = pc;
  assign MEM_RDEN = IF_RST_N && !redirect && !STALL;
  always_comb target = PC_SOURCE == 2'b01 ? {JALR[31:1], 1'b0} : PC_SOURCE == 2'b10 ? BRANCH : JAL;
  always_ff @(posedge IF_CLK) begin
    if (!IF_RST_N) begin
      pc         <= RESET_VECTOR;
      req_valid  <= 1'b0;
      req_pc     <= RESET_VECTOR;
      skid_valid <= 1'b0;
      skid_pc    <= RESET_VECTOR;
      skid_ir    <= NOP_INSTR;
      IF_VALID   <= 1'b0;
      IF_PC      <= RESET_VECTOR;
      IF_IR      <= NOP_INSTR;
    end else if (redirect) begin
      pc         <= target;
      req_valid  <= 1'b0;
      skid_valid <= 1'b0;
      IF_VALID   <= 1'b0;
      IF_IR      <= NOP_INSTR;
    end else if (STALL) begin
      if (req_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= req_pc;
        skid_ir    <= MEM_INSTR;
        req_valid  <= 1'b0;
      end
    end else begin
      req_valid  <= 1'b1;
      req_pc     <= pc;
      pc         <= pc + 32'd4;
      skid_valid <= 1'b0;
      IF_VALID   <= skid_valid || req_valid;
      IF_PC      <= skid_valid ? skid_pc : req_pc;
      IF_IR      <= skid_valid ? skid_ir : req_valid ? MEM_INSTR : NOP_INSTR;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle-by-cycle check of fetch_stage against a 1-cycle imem returning instr=addr
module tb_fetch_stage;
  localparam logic [31:0] N = 32'h0000_0013;
  localparam logic [31:0] G = 32'hDEAD_BEE0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ps = 2'b00;
  logic [31:0] jalr = G, branch = G, jal = G;
  logic        stall = 1'b0;
  logic [31:0] mem_q = 32'hBAD0_BAD0;
  logic [31:0] mem_addr, if_pc, if_ir;
  logic        mem_rden, if_valid, flush;
  int checks = 0, errors = 0;

  typedef struct {
    logic        rst_n, stall;
    logic [1:0]  ps;
    logic [31:0] tgt;
    logic        v, cpc;
    logic [31:0] pc, ir, addr;
    logic        rden, flush;
  } vec_t;
  vec_t tv[34];

  fetch_stage dut (
    .IF_CLK(clk), .IF_RST_N(rst_n), .PC_SOURCE(ps), .JALR(jalr), .BRANCH(branch), .JAL(jal),
    .STALL(stall), .MEM_INSTR(mem_q), .MEM_ADDR(mem_addr), .MEM_RDEN(mem_rden),
    .IF_PC(if_pc), .IF_IR(if_ir), .IF_VALID(if_valid), .FLUSH(flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_q <= mem_rden ? mem_addr : 32'hBAD0_BAD0;

  task automatic chk(input string n, input int row, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", n, row, a, e);
    end
  endtask

  initial begin
    tv[0]  = '{0,0,0,0,       0,1,32'h0,  N,         32'h0,   0,0};
    tv[1]  = '{1,0,0,0,       0,0,32'h0,  N,         32'h0,   1,0};
    tv[2]  = '{1,0,0,0,       0,0,32'h0,  N,         32'h4,   1,0};
    tv[3]  = '{1,0,0,0,       1,1,32'h0,  32'h0,     32'h8,   1,0};
    tv[4]  = '{1,0,0,0,       1,1,32'h4,  32'h4,     32'hC,   1,0};
    tv[5]  = '{1,0,0,0,       1,1,32'h8,  32'h8,     32'h10,  1,0};
    tv[6]  = '{1,1,0,0,       1,1,32'hC,  32'hC,     32'h14,  0,0};
    tv[7]  = '{1,1,0,0,       1,1,32'hC,  32'hC,     32'h14,  0,0};
    tv[8]  = '{1,1,0,0,       1,1,32'hC,  32'hC,     32'h14,  0,0};
    tv[9]  = '{1,0,0,0,       1,1,32'hC,  32'hC,     32'h14,  1,0};
    tv[10] = '{1,0,0,0,       1,1,32'h10, 32'h10,    32'h18,  1,0};
    tv[11] = '{1,0,3,32'h200, 1,1,32'h14, 32'h14,    32'h1C,  0,1};
    tv[12] = '{1,0,0,0,       0,0,32'h0,  N,         32'h200, 1,0};
    tv[13] = '{1,0,0,0,       0,0,32'h0,  N,         32'h204, 1,0};
    tv[14] = '{1,0,0,0,       1,1,32'h200,32'h200,   32'h208, 1,0};
    tv[15] = '{1,0,1,32'h105, 1,1,32'h204,32'h204,   32'h20C, 0,1};
    tv[16] = '{1,0,0,0,       0,0,32'h0,  N,         32'h104, 1,0};
    tv[17] = '{1,0,0,0,       0,0,32'h0,  N,         32'h108, 1,0};
    tv[18] = '{1,0,0,0,       1,1,32'h104,32'h104,   32'h10C, 1,0};
    tv[19] = '{1,1,0,0,       1,1,32'h108,32'h108,   32'h110, 0,0};
    tv[20] = '{1,1,2,32'h40,  1,1,32'h108,32'h108,   32'h110, 0,1};
    tv[21] = '{1,0,0,0,       0,0,32'h0,  N,         32'h40,  1,0};
    tv[22] = '{1,0,0,0,       0,0,32'h0,  N,         32'h44,  1,0};
    tv[23] = '{1,0,0,0,       1,1,32'h40, 32'h40,    32'h48,  1,0};
    tv[24] = '{1,1,0,0,       1,1,32'h44, 32'h44,    32'h4C,  0,0};
    tv[25] = '{0,1,0,0,       1,1,32'h44, 32'h44,    32'h4C,  0,0};
    tv[26] = '{1,0,0,0,       0,1,32'h0,  N,         32'h0,   1,0};
    tv[27] = '{1,0,0,0,       0,0,32'h0,  N,         32'h4,   1,0};
    tv[28] = '{1,0,0,0,       1,1,32'h0,  32'h0,     32'h8,   1,0};
    tv[29] = '{1,0,3,32'h300, 1,1,32'h4,  32'h4,     32'hC,   0,1};
    tv[30] = '{1,0,2,32'h500, 0,0,32'h0,  N,         32'h300, 0,1};
    tv[31] = '{1,0,0,0,       0,0,32'h0,  N,         32'h500, 1,0};
    tv[32] = '{1,0,0,0,       0,0,32'h0,  N,         32'h504, 1,0};
    tv[33] = '{1,0,0,0,       1,1,32'h500,32'h500,   32'h508, 1,0};
    @(posedge clk); #1;
    for (int i = 0; i < 34; i++) begin
      rst_n  = tv[i].rst_n;
      stall  = tv[i].stall;
      ps     = tv[i].ps;
      jalr   = tv[i].ps == 2'b01 ? tv[i].tgt : G;
      branch = tv[i].ps == 2'b10 ? tv[i].tgt : G;
      jal    = tv[i].ps == 2'b11 ? tv[i].tgt : G;
      #1;
      chk("IF_VALID", i, {31'd0, if_valid}, {31'd0, tv[i].v});
      chk("IF_IR", i, if_ir, tv[i].ir);
      if (tv[i].cpc) chk("IF_PC", i, if_pc, tv[i].pc);
      chk("MEM_ADDR", i, mem_addr, tv[i].addr);
      chk("MEM_RDEN", i, {31'd0, mem_rden}, {31'd0, tv[i].rden});
      chk("FLUSH", i, {31'd0, flush}, {31'd0, tv[i].flush});
      @(posedge clk); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined Otter core. Consumes the registered redirect outputs of the execute stage: PC_SOURCE plus the JALR, BRANCH and JAL targets. Maintains the PC and drives a synchronous-read instruction memory with 1-cycle read latency. Delivers PC/IR/valid to decode through a stall-safe output register backed by a 1-entry skid buffer, and generates the pipeline flush on every redirect.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value after reset.
NOP_INSTR, 32'h0000_0013, IR value driven on IF_IR when IF_VALID=0 (addi x0,x0,0).

Ports:
IF_CLK  input  1  stage clock; all state updates on its rising edge.
IF_RST_N  input  1  synchronous active-low reset.
PC_SOURCE  input  2  redirect select from execute: 00 sequential, 01 JALR, 10 BRANCH, 11 JAL.
JALR  input  32  JALR target.
BRANCH  input  32  taken-branch target.
JAL  input  32  JAL target.
STALL  input  1  hazard-unit hold request for decode.
MEM_INSTR  input  32  instruction memory read data; valid the cycle after a MEM_RDEN=1 cycle.
MEM_ADDR  output  32  fetch address, equal to the current PC.
MEM_RDEN  output  1  instruction memory read enable.
IF_PC  output  32  PC of the instruction presented to decode.
IF_IR  output  32  instruction presented to decode.
IF_VALID  output  1  IF_PC/IF_IR hold a live instruction.
FLUSH  output  1  squash decode/execute contents; combinational, equals (PC_SOURCE != 2'b00).

Behaviour:
- Reset (IF_RST_N=0 at an edge, even mid-stall or mid-redirect): PC=RESET_VECTOR, req_valid=0, skid_valid=0, IF_VALID=0, IF_IR=NOP_INSTR, IF_PC=RESET_VECTOR. Inputs are ignored while reset is asserted; MEM_RDEN=0 during reset cycles.
- State: PC register; outstanding request (req_valid, req_pc); skid buffer (skid_valid, skid_pc, skid_ir); IF output register.
- FSM derived from the flags:
  - RUN (skid empty).
  - HOLD (skid full, or STALL asserted).
  - Redirect is a priority event usable from either state.
- Priority per cycle: reset > redirect > STALL > normal.
- Target select: JALR target = {JALR[31:1],1'b0}; BRANCH and JAL are used as given. The PC only advances by 4; wrap modulo 2^32 is silent.
- Normal cycle (no redirect, STALL=0):
  - MEM_RDEN=1 and MEM_ADDR=PC.
  - At the edge: req_valid<=1, req_pc<=PC, PC<=PC+4.
  - IF register loads from the skid buffer if skid_valid (then skid_valid<=0); otherwise from {req_pc, MEM_INSTR, req_valid}.
  - Latency: a PC issued at cycle t appears on IF outputs in cycle t+2.
- Stall cycle (STALL=1, no redirect):
  - MEM_RDEN=0; PC holds; IF register holds.
  - If req_valid: skid<=({req_pc, MEM_INSTR}), skid_valid<=1, req_valid<=0.
  - The skid buffer can never overflow because MEM_RDEN=0 while stalled.
- Stall release: the skid buffer drains to IF in the first unstalled cycle, and a new fetch issues in that same cycle. There is no bubble and no lost or duplicated instruction.
- Redirect cycle (PC_SOURCE!=0; overrides STALL):
  - FLUSH=1 and MEM_RDEN=0.
  - At the edge: PC<=target; req_valid<=0; skid_valid<=0; IF_VALID<=0, IF_IR<=NOP_INSTR.
  - Fetch of the target starts in the next cycle. The target instruction reaches IF 3 cycles after the redirect cycle, or later if STALL is asserted.
- Back-to-back redirects: each one overrides the previous; the last target wins.
- IF_VALID=0 always pairs with IF_IR=NOP_INSTR.

Test Plan:
- Reset release with RESET_VECTOR=0, no stall, memory returning instr=addr: IF shows PC 0,4,8,... with IF_IR=0,4,8. First IF_VALID=1 appears 2 cycles after the first MEM_RDEN=1.
- STALL high for 3 cycles while PC=0x10 is outstanding: IF holds its value, MEM_RDEN=0, PC holds at 0x14. After release, IF shows 0x10 then 0x14 with no gap and no repeat.
- PC_SOURCE=11, JAL=0x200 for one cycle: FLUSH=1 that cycle and IF_VALID=0 next cycle. MEM_ADDR=0x200 next cycle; IF_PC=0x200 valid 3 cycles after the redirect.
- PC_SOURCE=01, JALR=0x0000_0105: fetch address is 0x104.
- Redirect (BRANCH=0x40) asserted together with STALL=1 while the skid buffer is full: skid and outstanding request are discarded, FLUSH=1, next MEM_ADDR=0x40.
- IF_RST_N=0 mid-stall with skid full: next cycle IF_VALID=0, IF_IR=0x13, PC=RESET_VECTOR, and fetch restarts cleanly.
